// File: rtl/proj1_pipe.sv
// proj1_pipe: CHANNELS x WIDTH lanes through a DEPTH-stage valid-tagged pipeline with backpressure
// Ports: clk, clear (sync active-high reset), in/ena_in/in_ready (upstream handshake),
//        out/ena_out/out_ready (downstream handshake), occupancy (valid stages), drop_count (saturating).
module proj1_pipe #(
  parameter int WIDTH = 24,
  parameter int CHANNELS = 2,
  parameter int DEPTH = 3,
  parameter int DROPW = 16
) (
  input  logic                        clk,
  input  logic                        clear,
  input  logic [CHANNELS*WIDTH-1:0]   in,
  input  logic                        ena_in,
  output logic                        in_ready,
  output logic [CHANNELS*WIDTH-1:0]   out,
  output logic                        ena_out,
  input  logic                        out_ready,
  output logic [$clog2(DEPTH+1)-1:0]  occupancy,
  output logic [DROPW-1:0]            drop_count
);
  localparam int DW = CHANNELS * WIDTH;
  logic [DEPTH-1:0] v, vs;
  logic [DEPTH:0] r;
  logic [DW-1:0] d [DEPTH];
  logic [DW-1:0] ds [DEPTH];
  logic acc, cons;
  // A stage may load when it is empty or everything downstream of it moves.
  always_comb begin
    r = '0;
    r[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) r[i] = !v[i] || r[i+1];
    vs = '0;
    ds = d;
    vs[0] = ena_in;
    ds[0] = in;
    for (int i = 1; i < DEPTH; i++) begin
      vs[i] = v[i-1];
      ds[i] = d[i-1];
    end
  end
  assign in_ready = r[0];
  assign out = d[DEPTH-1];
  assign ena_out = v[DEPTH-1];
  assign acc = ena_in && r[0];
  assign cons = v[DEPTH-1] && out_ready;
  always_ff @(posedge clk) begin
    if (clear) begin
      v <= '0;
      for (int i = 0; i < DEPTH; i++) d[i] <= '0;
      occupancy <= '0;
      drop_count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (r[i]) begin
          v[i] <= vs[i];
          if (vs[i]) d[i] <= ds[i];
        end
      if (acc != cons) occupancy <= acc ? occupancy + 1'b1 : occupancy - 1'b1;
      if (ena_in && !r[0] && drop_count != '1) drop_count <= drop_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_proj1_pipe.sv
// tb_proj1_pipe: randomized and directed checks of proj1_pipe against a queue-of-positions model
module tb_proj1_pipe;
  localparam int DEPTH = 3;
  localparam int DW = 48;
  logic clk = 0, clear, ena_in, out_ready, in_ready, ena_out;
  logic [DW-1:0] din, dout;
  logic [1:0] occupancy;
  logic [15:0] drop_count;
  int total = 0, bad = 0;
  logic [DW-1:0] mq[$];
  int mp[$];
  int mdrop = 0;

  proj1_pipe dut (
    .clk(clk), .clear(clear), .in(din), .ena_in(ena_in), .in_ready(in_ready),
    .out(dout), .ena_out(ena_out), .out_ready(out_ready),
    .occupancy(occupancy), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: words queued oldest first, each with a stage position; a word advances
  // one stage unless blocked by the word ahead; the head leaves from the last stage
  // when out_ready is high.
  task automatic step(input bit c, input logic [DW-1:0] w, input bit e, input bit o);
    bit rdy, exp_v;
    int lim, np;
    clear = c; din = w; ena_in = e; out_ready = o;
    #1;
    rdy = mq.size() < DEPTH || o;
    if (!c) chk("in_ready", {63'd0, in_ready}, {63'd0, rdy});
    @(posedge clk);
    if (c) begin
      mq.delete(); mp.delete(); mdrop = 0;
    end else begin
      lim = o ? DEPTH : DEPTH - 1;
      for (int k = 0; k < mp.size(); k++) begin
        np = (mp[k] + 1 < lim) ? mp[k] + 1 : lim;
        mp[k] = np;
        lim = np - 1;
      end
      if (mp.size() > 0 && mp[0] == DEPTH) begin
        void'(mp.pop_front()); void'(mq.pop_front());
      end
      if (e && rdy) begin
        mq.push_back(w); mp.push_back(0);
      end else if (e && mdrop < 65535) mdrop++;
    end
    @(negedge clk);
    exp_v = mp.size() > 0 && mp[0] == DEPTH - 1;
    chk("ena_out", {63'd0, ena_out}, {63'd0, exp_v});
    if (exp_v) chk("out", {16'd0, dout}, {16'd0, mq[0]});
    chk("occupancy", {62'd0, occupancy}, 64'(mq.size()));
    chk("drop_count", {48'd0, drop_count}, 64'(mdrop));
  endtask

  function automatic logic [DW-1:0] word(input int i);
    return {24'hA00000 + 24'(i), 24'(i)};
  endfunction

  function automatic logic [DW-1:0] rnd();
    return DW'({$urandom(), $urandom()});
  endfunction

  initial begin
    repeat (2) step(1, rnd(), 1'($urandom), 1'($urandom));
    chk("rst_out", {16'd0, dout}, 64'd0);
    chk("rst_ena", {63'd0, ena_out}, 64'd0);
    chk("rst_occ", {62'd0, occupancy}, 64'd0);
    chk("rst_drop", {48'd0, drop_count}, 64'd0);
    for (int i = 1; i <= 5; i++) step(0, word(i), 1, 1);
    chk("stream_occ", {62'd0, occupancy}, 64'd3);
    repeat (4) step(0, rnd(), 0, 1);
    for (int i = 1; i <= 5; i++) step(0, word(i + 16), 1, 0);
    chk("bp_rdy", {63'd0, in_ready}, 64'd0);
    chk("bp_occ", {62'd0, occupancy}, 64'd3);
    chk("bp_drop", {48'd0, drop_count}, 64'd2);
    repeat (4) step(0, rnd(), 0, 1);
    step(0, word(32), 1, 0);
    step(0, rnd(), 0, 0);
    step(0, word(33), 1, 0);
    repeat (3) step(0, rnd(), 0, 0);
    chk("bub_occ", {62'd0, occupancy}, 64'd2);
    chk("bub_rdy", {63'd0, in_ready}, 64'd1);
    step(0, word(34), 1, 0);
    step(0, word(35), 1, 1);
    chk("full_occ", {62'd0, occupancy}, 64'd3);
    chk("full_drop", {48'd0, drop_count}, 64'd2);
    repeat (4) step(0, rnd(), 0, 1);
    step(0, word(40), 1, 1);
    step(0, word(41), 1, 1);
    step(1, rnd(), 0, 1);
    repeat (4) step(0, rnd(), 0, 1);
    chk("clr_occ", {62'd0, occupancy}, 64'd0);
    for (int n = 0; n < 3000; n++)
      step($urandom_range(0, 63) == 0, rnd(), 1'($urandom), 1'($urandom));
    step(1, rnd(), 0, 0);
    repeat (65536 + 3 + 3) step(0, rnd(), 1, 0);
    chk("drop_sat", {48'd0, drop_count}, 64'hFFFF);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
